// File: rtl/mc_comp32_core.sv
// mc_comp32_core
//   Multi-cycle 32-bit MIPS-subset CPU with one unified instruction/data
//   memory port. The port uses a req/ready handshake, so the memory may
//   insert any number of wait states.
//
//   Supported instructions:
//     R-type : add sub and or slt sll srl
//     I-type : addi andi ori lui lw sw beq bne
//     J-type : j
//   Any other opcode or funct halts the core.
//
//   Ports
//     clk        in   clock; all state updates on the rising edge
//     rst        in   synchronous active-high reset
//     mem_req    out  memory access request
//     mem_we     out  write strobe, meaningful while mem_req=1
//     mem_addr   out  word-aligned byte address (ADDR_W bits)
//     mem_wdata  out  store data
//     mem_rdata  in   fetch/load data, valid when mem_ready=1
//     mem_ready  in   a transfer completes when mem_req && mem_ready
//     pc         out  program counter
//     inst       out  instruction register
//     aluout     out  registered ALU result
//     halted     out  sticky until rst; set on an illegal instruction
//     retired    out  completed-instruction count, wraps at 2^CNT_W
module mc_comp32_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic [31:0]       inst,
  output logic [31:0]       aluout,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        inst_q, inst_d;
  logic [31:0]        aluout_q, aluout_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        target_q, target_d;
  logic [31:0]        mdr_q, mdr_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        regs_q [32];

  logic               wr_en;
  logic [4:0]         wr_idx;
  logic [31:0]        wr_data;

  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd, shamt;
  logic [15:0]        imm;
  logic signed [31:0] imm_sx;
  logic [31:0]        rs_val, rt_val;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic is_legal(input logic [5:0] o, input logic [5:0] f);
    logic ok;
    ok = 1'b0;
    case (o)
      OP_RTYPE: ok = (f == FN_SLL) || (f == FN_SRL) || (f == FN_ADD) || (f == FN_SUB) ||
                     (f == FN_AND) || (f == FN_OR)  || (f == FN_SLT);
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] alu(input logic [5:0] o, input logic [5:0] f,
                                      input logic [4:0] sh, input logic [31:0] a,
                                      input logic [31:0] b, input logic [15:0] im);
    logic signed [31:0] sa, sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    case (o)
      OP_RTYPE: begin
        case (f)
          FN_ADD:  r = a + b;
          FN_SUB:  r = a - b;
          FN_AND:  r = a & b;
          FN_OR:   r = a | b;
          FN_SLT:  r = {31'd0, sa < sb};
          FN_SLL:  r = b << sh;
          FN_SRL:  r = b >> sh;
          default: r = '0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: r = a + $unsigned(sext16(im));
      OP_ANDI: r = a & {16'd0, im};
      OP_ORI:  r = a | {16'd0, im};
      OP_LUI:  r = {im, 16'd0};
      OP_BEQ, OP_BNE: r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign op     = inst_q[31:26];
  assign rs     = inst_q[25:21];
  assign rt     = inst_q[20:16];
  assign rd     = inst_q[15:11];
  assign shamt  = inst_q[10:6];
  assign funct  = inst_q[5:0];
  assign imm    = inst_q[15:0];
  assign imm_sx = sext16(imm);

  // Register $0 is hardwired to zero on the read side.
  assign rs_val = (rs == 5'd0) ? 32'd0 : regs_q[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : regs_q[rt];

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    aluout_d  = aluout_q;
    a_d       = a_q;
    b_d       = b_q;
    target_d  = target_q;
    mdr_d     = mdr_q;
    retired_d = retired_q;
    wr_en     = 1'b0;
    wr_idx    = rt;
    wr_data   = aluout_q;
    req_d     = 1'b0;
    we_d      = 1'b0;
    addr_d    = '0;
    wdata_d   = '0;

    case (state_q)
      S_FETCH: begin
        if (req_q && mem_ready) begin
          inst_d  = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rs_val;
        b_d      = rt_val;
        // pc already points past this instruction
        target_d = pc_q + {imm_sx[29:0], 2'b00};
        if (!is_legal(op, funct)) begin
          state_d = S_HALT;
        end else if (op == OP_J) begin
          pc_d      = {pc_q[31:28], inst_q[25:0], 2'b00};
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        aluout_d = alu(op, funct, shamt, a_q, b_q, imm);
        if (op == OP_BEQ || op == OP_BNE) begin
          if ((a_q == b_q) == (op == OP_BEQ)) pc_d = target_q;
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else if (op == OP_LW || op == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (req_q && mem_ready) begin
          if (op == OP_SW) begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        wr_en     = 1'b1;
        wr_idx    = (op == OP_RTYPE) ? rd : rt;
        wr_data   = (op == OP_LW) ? mdr_q : aluout_q;
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // The memory port is registered and set up for the state being
    // entered, so a FETCH/MEM state requests from its first cycle. While a
    // transfer waits, pc_d/aluout_d/b_q are unchanged, keeping the port
    // stable. Right after reset the port is idle for one cycle.
    req_d = (state_d == S_FETCH) || (state_d == S_MEM);
    if (state_d == S_FETCH) begin
      addr_d = {pc_d[31:2], 2'b00};
    end else if (state_d == S_MEM) begin
      addr_d = {aluout_d[31:2], 2'b00};
      if (op == OP_SW) begin
        we_d    = 1'b1;
        wdata_d = b_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      aluout_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      target_q  <= '0;
      mdr_q     <= '0;
      retired_q <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      aluout_q  <= aluout_d;
      a_q       <= a_d;
      b_q       <= b_d;
      target_q  <= target_d;
      mdr_q     <= mdr_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if (wr_en && (wr_idx != 5'd0)) regs_q[wr_idx] <= wr_data;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q[ADDR_W-1:0];
  assign mem_wdata = wdata_q;
  assign pc        = pc_q;
  assign inst      = inst_q;
  assign aluout    = aluout_q;
  assign halted    = (state_q == S_HALT);
  assign retired   = retired_q;

endmodule

// File: tb/tb_mc_comp32_core.sv
// Testbench for mc_comp32_core: a unified memory model with programmable
// wait states, a transfer scoreboard, and directed programs.
module tb_mc_comp32_core;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, inst, aluout, retired;

  logic        rst2;
  logic        mem_req2, mem_we2, mem_ready2, halted2;
  logic [31:0] mem_addr2, mem_wdata2, mem_rdata2, pc2, inst2, aluout2;
  logic [3:0]  retired2;

  mc_comp32_core dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .inst(inst), .aluout(aluout), .halted(halted), .retired(retired)
  );

  mc_comp32_core #(.CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .mem_ready(mem_ready2),
    .pc(pc2), .inst(inst2), .aluout(aluout2), .halted(halted2), .retired(retired2)
  );

  // dut2 executes an endless stream of NOPs (all-zero word = sll $0,$0,0)
  assign mem_rdata2 = 32'd0;
  assign mem_ready2 = mem_req2;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       exp_q[$];
  xfer_t       obs_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic        stall_we = 1'b0;
  int          stab_err = 0;
  logic        hold = 1'b0;
  logic        p_we;
  logic [31:0] p_addr, p_wdata;
  logic [31:0] mem [256];
  int          cyc;

  localparam logic [31:0] ILL = 32'hFC00_0000;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = mem_req && (wcnt >= wait_n) && !(stall_we && mem_we);

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int im);
    return {6'(op), 5'(rs), 5'(rt), 16'(im)};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_j(input int tgt);
    return {6'h02, 26'(tgt)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // One clock: sample the port mid-cycle, let the edge happen, then update
  // the memory model with the transfer that completed at that edge.
  task automatic step();
    logic        s_req, s_rdy, s_we, s_rst;
    logic [31:0] s_addr, s_wd;
    @(negedge clk);
    s_req = mem_req; s_rdy = mem_ready; s_we = mem_we;
    s_addr = mem_addr; s_wd = mem_wdata; s_rst = rst;
    if (hold && !s_rst &&
        (s_req !== 1'b1 || s_addr !== p_addr || s_we !== p_we || s_wd !== p_wdata))
      stab_err++;
    hold = s_req && !s_rdy && !s_rst;
    p_addr = s_addr; p_we = s_we; p_wdata = s_wd;
    @(posedge clk);
    #1;
    if (s_req && s_rdy && !s_rst) begin
      obs_q.push_back('{we: s_we, addr: s_addr, data: (s_we ? s_wd : 32'd0)});
      if (s_we) mem[s_addr[9:2]] = s_wd;
    end
    if (!s_req || s_rdy || s_rst) wcnt = 0;
    else wcnt++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  task automatic push_x(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back('{we: we, addr: addr, data: data});
  endtask

  task automatic start_prog(input int wn);
    int k;
    wait_n = wn; stab_err = 0; hold = 1'b0;
    obs_q.delete();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    k = 0;
    while (!mem_req && k < 10) begin
      step();
      k++;
    end
    chk("req_after_reset", 32'(mem_req), 32'd1);
  endtask

  task automatic run_until_retired(input logic [31:0] n, input int budget, output int c);
    c = 0;
    while (retired !== n && c < budget) begin
      step();
      c++;
    end
    chk("retire_reached", retired, n);
  endtask

  task automatic run_until_halt(input string tag, input int budget);
    int k;
    k = 0;
    while (halted !== 1'b1 && k < budget) begin
      step();
      k++;
    end
    chk({tag, "_halt"}, 32'(halted), 32'd1);
  endtask

  task automatic check_xfers(input string tag);
    chk({tag, "_xfer_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      xfer_t e, o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_xfer_addr"}, o.addr, e.addr);
      chk({tag, "_xfer_we"}, 32'(o.we), 32'(e.we));
      if (e.we) chk({tag, "_xfer_wdata"}, o.data, e.data);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic load_main();
    clear_mem();
    mem[0] = enc_i(8'h08, 0, 1, 5);
    mem[1] = enc_i(8'h08, 0, 2, -3);
    mem[2] = enc_r(1, 2, 3, 0, 8'h20);
    mem[3] = enc_i(8'h2B, 0, 3, 8);
    mem[4] = enc_i(8'h23, 0, 4, 8);
    mem[5] = ILL;
    exp_q.delete();
    push_x(0, 32'h00, 0); push_x(0, 32'h04, 0); push_x(0, 32'h08, 0);
    push_x(0, 32'h0C, 0); push_x(1, 32'h08, 2); push_x(0, 32'h10, 0);
    push_x(0, 32'h08, 0); push_x(0, 32'h14, 0);
  endtask

  task automatic load_branch(input int br_op);
    clear_mem();
    mem[0] = enc_i(8'h08, 0, 1, 7);
    mem[1] = enc_i(8'h08, 0, 2, 7);
    mem[4] = enc_i(br_op, 1, 2, 2);
    mem[5] = enc_j(32'h40);
    mem[7] = enc_j(32'h40);
    mem[64] = ILL;
    exp_q.delete();
    push_x(0, 32'h00, 0); push_x(0, 32'h04, 0); push_x(0, 32'h08, 0);
    push_x(0, 32'h0C, 0); push_x(0, 32'h10, 0);
    push_x(0, (br_op == 4) ? 32'h1C : 32'h14, 0);
    push_x(0, 32'h100, 0);
  endtask

  initial begin
    rst = 1'b1;
    rst2 = 1'b1;
    clear_mem();
    step();
    step();

    // Reset state
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_aluout", aluout, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);

    // Main program, zero wait states
    load_main();
    start_prog(0);
    run_until_retired(32'd5, 100, cyc);
    chk("main0_cycles", 32'(cyc), 32'd21);
    chk("main0_r3", dut.regs_q[3], 32'd2);
    chk("main0_r4", dut.regs_q[4], 32'd2);
    chk("main0_mem8", mem[2], 32'd2);
    run_until_halt("main0", 50);
    chk("main0_retired_after_halt", retired, 32'd5);
    check_xfers("main0");

    // Main program, 3 wait states on every access
    load_main();
    start_prog(3);
    run_until_retired(32'd5, 200, cyc);
    chk("main3_cycles", 32'(cyc), 32'd42);
    chk("main3_r3", dut.regs_q[3], 32'd2);
    chk("main3_r4", dut.regs_q[4], 32'd2);
    chk("main3_mem8", mem[2], 32'd2);
    run_until_halt("main3", 100);
    chk("main3_stable_errs", 32'(stab_err), 32'd0);
    check_xfers("main3");

    // beq taken / bne not taken, then j 0x40
    load_branch(4);
    start_prog(0);
    run_until_halt("beq", 100);
    chk("beq_retired", retired, 32'd6);
    check_xfers("beq");
    load_branch(5);
    start_prog(0);
    run_until_halt("bne", 100);
    chk("bne_retired", retired, 32'd6);
    check_xfers("bne");

    // Arithmetic edge cases
    clear_mem();
    exp_q.delete();
    mem[0]  = enc_i(8'h08, 0, 0, 9);
    mem[1]  = enc_i(8'h0F, 0, 5, 16'h7FFF);
    mem[2]  = enc_i(8'h0D, 5, 5, 16'hFFFF);
    mem[3]  = enc_i(8'h08, 5, 6, 1);
    mem[4]  = enc_i(8'h08, 0, 7, -1);
    mem[5]  = enc_i(8'h08, 0, 8, 1);
    mem[6]  = enc_r(7, 8, 9, 0, 8'h2A);
    mem[7]  = enc_i(8'h0F, 0, 10, 16'hABCD);
    mem[8]  = enc_r(8, 7, 11, 0, 8'h22);
    mem[9]  = enc_r(0, 8, 12, 4, 8'h00);
    mem[10] = enc_r(0, 7, 13, 28, 8'h02);
    mem[11] = enc_r(5, 10, 14, 0, 8'h24);
    mem[12] = enc_i(8'h0C, 7, 16, 16'hFFFF);
    mem[13] = ILL;
    start_prog(0);
    run_until_halt("edge", 200);
    chk("edge_r0", dut.regs_q[0], 32'h0);
    chk("edge_addi_wrap", dut.regs_q[6], 32'h8000_0000);
    chk("edge_slt", dut.regs_q[9], 32'h1);
    chk("edge_lui", dut.regs_q[10], 32'hABCD_0000);
    chk("edge_sub", dut.regs_q[11], 32'h2);
    chk("edge_sll", dut.regs_q[12], 32'h10);
    chk("edge_srl", dut.regs_q[13], 32'hF);
    chk("edge_and", dut.regs_q[14], 32'h2BCD_0000);
    chk("edge_andi_zext", dut.regs_q[16], 32'h0000_FFFF);
    chk("edge_retired", retired, 32'd13);

    // Illegal opcode at the first fetch
    clear_mem();
    exp_q.delete();
    mem[0] = ILL;
    push_x(0, 32'h0, 0);
    start_prog(0);
    step();
    chk("ill_decode_not_halted", 32'(halted), 32'd0);
    step();
    chk("ill_halted", 32'(halted), 32'd1);
    chk("ill_req_low", 32'(mem_req), 32'd0);
    repeat (5) step();
    chk("ill_req_stays_low", 32'(mem_req), 32'd0);
    chk("ill_retired", retired, 32'd0);
    chk("ill_still_halted", 32'(halted), 32'd1);
    check_xfers("ill");

    // Reset while a store is waiting in MEM
    clear_mem();
    exp_q.delete();
    mem[0] = enc_i(8'h08, 0, 1, 16'h55);
    mem[1] = enc_i(8'h2B, 0, 1, 16'h20);
    mem[2] = ILL;
    mem[8] = 32'hDEAD;
    stall_we = 1'b1;
    start_prog(0);
    begin
      int k;
      k = 0;
      while (!(mem_req && mem_we) && k < 30) begin
        step();
        k++;
      end
    end
    step();
    step();
    chk("rmid_req_held", 32'(mem_req), 32'd1);
    chk("rmid_addr_held", mem_addr, 32'h20);
    chk("rmid_wdata_held", mem_wdata, 32'h55);
    rst = 1'b1;
    step();
    chk("rmid_req_dropped", 32'(mem_req), 32'd0);
    chk("rmid_pc", pc, 32'h0);
    chk("rmid_retired", retired, 32'd0);
    chk("rmid_no_write", mem[8], 32'hDEAD);
    chk("rmid_xfers_before", 32'(obs_q.size()), 32'd2);
    obs_q.delete();
    rst = 1'b0;
    stall_we = 1'b0;
    push_x(0, 32'h00, 0); push_x(0, 32'h04, 0);
    push_x(1, 32'h20, 32'h55); push_x(0, 32'h08, 0);
    run_until_halt("rmid", 100);
    chk("rmid_store_after_restart", mem[8], 32'h55);
    chk("rmid_retired_after", retired, 32'd2);
    check_xfers("rmid");

    // 4-bit retired counter wraps: 17 NOPs leave it at 1
    rst2 = 1'b0;
    repeat (68) step();
    chk("cnt4_after_16", 32'(retired2), 32'd0);
    step();
    chk("cnt4_after_17", 32'(retired2), 32'd1);
    chk("cnt4_pc", pc2, 32'h44);
    chk("cnt4_addr", mem_addr2, 32'h44);
    chk("cnt4_inst", inst2, 32'h0);
    chk("cnt4_aluout", aluout2, 32'h0);
    chk("cnt4_wdata", mem_wdata2, 32'h0);
    chk("cnt4_quiet", 32'(halted2 | mem_we2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mc_comp32_core.md
Name: mc_comp32_core

Overview:
- Multi-cycle successor to the single-cycle computer: a 32-bit MIPS-subset CPU using one unified instruction/data memory port.
- The port has a req/ready handshake, so the memory may insert any number of wait states.
- An FSM replaces the single-cycle datapath. Instructions take 2-5 cycles plus memory wait cycles.
- The block is a drop-in core for the next-generation top, which adds only a memory model with configurable latency.

Parameters:
- RESET_PC, 32'h0000_0000: pc value loaded on reset.
- ADDR_W, 32: width of mem_addr. It is pc/aluout truncated to the low ADDR_W bits, with ADDR_W <= 32.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- mem_req, output, 1: memory access request.
- mem_we, output, 1: write strobe; valid while mem_req=1.
- mem_addr, output, ADDR_W: byte address, word-aligned.
- mem_wdata, output, 32: store data.
- mem_rdata, input, 32: load/fetch data; valid in the cycle mem_ready=1.
- mem_ready, input, 1: transfer completes in a cycle where mem_req=1 and mem_ready=1.
- pc, output, 32: current program counter.
- inst, output, 32: instruction register.
- aluout, output, 32: registered ALU result.
- halted, output, 1: set on an illegal opcode; sticky until rst.
- retired, output, CNT_W: count of completed instructions, wrapping modulo 2^CNT_W.

Behaviour:
- Reset values:
  - pc=RESET_PC; inst=0; aluout=0; retired=0; halted=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - All 32 registers = 0; state=FETCH.
  - Reset mid-transfer abandons the transfer: mem_req=0 on the cycle after rst is sampled, and nothing is written to state.
- FSM states and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ready. On mem_ready: inst<=mem_rdata, pc<=pc+4, go to DECODE.
  - DECODE: read rs/rt. Compute branch target = pc + (sign-ext imm << 2), where pc is already +4.
    - j: pc <= {pc[31:28], target, 2'b00}, retire, go to FETCH.
    - Illegal opcode or funct: go to HALT.
    - Otherwise go to EXEC.
  - EXEC: aluout <= ALU result.
    - beq/bne: if the condition holds, pc <= branch target. Retire, go to FETCH.
    - lw/sw: go to MEM.
    - All others: go to WB.
  - MEM: mem_req=1, mem_addr=aluout. For sw: mem_we=1, mem_wdata=rt.
    - Hold until mem_ready.
    - sw: retire, go to FETCH.
    - lw: capture mem_rdata into the MDR, go to WB.
  - WB: write rd (R-type) or rt (I-type/lw), retire, go to FETCH.
  - HALT: halted=1, mem_req=0. Absorbing state; only rst exits.
- Supported instructions:
  - R-type: add, sub, and, or, slt, sll, srl.
  - I-type: addi, andi, ori, lui, lw, sw, beq, bne.
  - Jump: j.
- Arithmetic and width rules:
  - add/sub/addi wrap with no overflow trap.
  - slt is signed.
  - andi/ori zero-extend the immediate; addi, lw, sw and branch offsets sign-extend it.
  - lui produces imm<<16.
  - Shifts use shamt.
- Register $0 reads as 0; writes to it are discarded.
- Cycle counts with zero wait states: j=2; beq/bne=3; R-type, ALU-immediate and sw=4; lw=5. Each memory wait cycle adds 1.
- mem_addr, mem_we and mem_wdata hold stable while mem_req=1 and mem_ready=0. mem_req never drops before completion except on rst.
- retired increments by exactly 1 in the retiring cycle and wraps at 2^CNT_W. It is not incremented for the instruction that halts.
- Misaligned lw/sw addresses: the low 2 bits are forced to 0 on mem_addr; no trap.

Test Plan:
- Zero-wait program "addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sw $3,8($0); lw $4,8($0)" -> $3=2, mem[8]=2, $4=2, retired=5 after 4+4+4+4+5=21 cycles.
- Same program with the memory inserting 3 wait cycles on every access -> identical architectural results in 21+7×3=42 cycles; mem_addr/mem_we/mem_wdata stable throughout each wait.
- Branches with $1=$2=7:
  - beq at pc 0x10 with offset 2 -> next fetch at 0x1C.
  - bne with the same operands -> next fetch at 0x14.
  - j 0x40 -> next fetch at 0x100.
- Edge cases:
  - addi $0,$0,9 -> $0 still reads 0.
  - addi 0x7FFF_FFFF+1 -> 0x8000_0000, no trap.
  - slt of -1 vs 1 -> 1.
  - lui 0xABCD -> 0xABCD_0000.
- Illegal opcode 6'h3F -> halted=1 two cycles after fetch completes; mem_req=0 thereafter; retired unchanged.
- Reset mid-run:
  - Assert rst during a MEM-state sw with mem_ready=0 -> no write occurs; pc=RESET_PC, retired=0, mem_req=0 next cycle; FETCH restarts cleanly.
  - CNT_W=4 with 17 retired instructions -> retired=1.
